rom16_arbiter: RTL and testbench

Round-robin arbiter that shares one ROM16 (16x1 LUT ROM) instance between four requesters. Each requester presents a 4-bit address with a request. The arbiter grants one requester per cycle and returns the registered ROM bit tagged with the requester ID. A valid/ready handshake on the response side lets a slow consumer stall the arbiter. It sits between small control FSMs that need a shared, ROM-based bit lookup (pattern tables, flags) and a single ROM16 primitive.

---
 rtl/rom16_arbiter.sv | 99 +++++++++
 tb/tb_rom16_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/rom16_arbiter.sv
// rom16_arbiter: four-way round-robin arbiter in front of one 16x1 ROM.
// Ports: CLK/RESETN, REQ/ADDR in, GNT out, VLD/VLD_ID/DO_R response, RDY.

module rom16 #(
  parameter logic [15:0] INIT = 16'h0
) (
  input  logic [3:0] a_i,
  output logic       do_o
);
  assign do_o = INIT[a_i];
endmodule

module rom16_arbiter #(
  parameter logic [15:0] INIT_0 = 16'h0
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic [3:0]  REQ,
  input  logic [15:0] ADDR,
  output logic [3:0]  GNT,
  output logic        VLD,
  output logic [1:0]  VLD_ID,
  output logic        DO_R,
  input  logic        RDY
);

  logic [1:0] ptr_q, ptr_d;
  logic       vld_q, vld_d;
  logic [1:0] id_q, id_d;
  logic       do_q, do_d;

  logic       win_vld;
  logic [1:0] win;
  logic [1:0] idx;
  logic       acc;
  logic [3:0] rom_addr;
  logic       rom_bit;

  // First requester at or after the pointer wins; with no
  // requester the pointer's own slice addresses the ROM.
  always_comb begin
    win_vld = 1'b0;
    win     = ptr_q;
    idx     = ptr_q;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!win_vld && REQ[idx]) begin
        win_vld = 1'b1;
        win     = idx;
      end
    end
  end

  // RESETN gates acceptance so GNT is low during reset.
  assign acc      = RESETN && win_vld && (!vld_q || RDY);
  assign rom_addr = ADDR[{win, 2'b00} +: 4];
  assign GNT      = acc ? (4'b0001 << win) : 4'b0000;

  rom16 #(
    .INIT (INIT_0)
  ) u_rom (
    .a_i  (rom_addr),
    .do_o (rom_bit)
  );

  always_comb begin
    ptr_d = ptr_q;
    vld_d = vld_q;
    id_d  = id_q;
    do_d  = do_q;
    if (acc) begin
      vld_d = 1'b1;
      id_d  = win;
      do_d  = rom_bit;
      ptr_d = win + 2'd1;
    end else if (vld_q && RDY) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      ptr_q <= 2'd0;
      vld_q <= 1'b0;
      id_q  <= 2'd0;
      do_q  <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      vld_q <= vld_d;
      id_q  <= id_d;
      do_q  <= do_d;
    end
  end

  assign VLD    = vld_q;
  assign VLD_ID = id_q;
  assign DO_R   = do_q;

endmodule

// File: tb/tb_rom16_arbiter.sv
// tb_rom16_arbiter: directed vector table, async reset sequences,
// and randomized traffic against a behavioural arbiter model.

module tb_rom16_arbiter;

  localparam logic [15:0] ROMC = 16'hA5C3;

  logic        CLK;
  logic        RESETN;
  logic [3:0]  REQ;
  logic [15:0] ADDR;
  logic [3:0]  GNT;
  logic        VLD;
  logic [1:0]  VLD_ID;
  logic        DO_R;
  logic        RDY;

  rom16_arbiter #(
    .INIT_0 (ROMC)
  ) dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .REQ    (REQ),
    .ADDR   (ADDR),
    .GNT    (GNT),
    .VLD    (VLD),
    .VLD_ID (VLD_ID),
    .DO_R   (DO_R),
    .RDY    (RDY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] addr;
    logic        rdy;
    logic [7:0]  exp;
  } vec_t;

  vec_t vt[18];

  int n_cmp = 0;
  int n_bad = 0;

  int         m_ptr;
  logic       m_vld;
  logic [1:0] m_id;
  logic       m_do;

  function automatic vec_t mk(logic [3:0] r, logic [15:0] a,
                              logic rd, logic [3:0] g,
                              logic v, logic [1:0] id, logic d);
    vec_t t;
    t.req  = r;
    t.addr = a;
    t.rdy  = rd;
    t.exp  = {g, v, id, d};
    return t;
  endfunction

  function automatic logic [7:0] obs();
    return {GNT, VLD, VLD_ID, DO_R};
  endfunction

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got gnt=%b vld=%b id=%0d do=%b, want gnt=%b vld=%b id=%0d do=%b",
               nm, act[7:4], act[3], act[2:1], act[0],
               exp[7:4], exp[3], exp[2:1], exp[0]);
    end
  endtask

  // Reference: scan from the pointer with modular arithmetic.
  function automatic int m_winner(logic [3:0] r);
    for (int k = 0; k < 4; k++)
      if (r[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return -1;
  endfunction

  task automatic m_reset();
    m_ptr = 0;
    m_vld = 1'b0;
    m_id  = 2'd0;
    m_do  = 1'b0;
  endtask

  // One cycle: inputs after posedge, check at negedge,
  // model advances on the following posedge.
  task automatic cyc(logic [3:0] r, logic [15:0] a, logic rd);
    int w;
    logic acc;
    logic [3:0] eg;
    REQ  = r;
    ADDR = a;
    RDY  = rd;
    w    = m_winner(r);
    acc  = (w >= 0) && (!m_vld || rd);
    eg   = acc ? 4'(1 << w) : 4'b0;
    @(negedge CLK);
    chk("random", obs(), {eg, m_vld, m_id, m_do});
    @(posedge CLK);
    if (acc) begin
      m_vld = 1'b1;
      m_id  = 2'(w);
      m_do  = ROMC[a[w*4 +: 4]];
      m_ptr = (w + 1) % 4;
    end else if (m_vld && rd) begin
      m_vld = 1'b0;
    end
    #1;
  endtask

  initial begin
    vt[0]  = mk(4'hF, 16'hC840, 1, 4'b0001, 0, 0, 0);
    vt[1]  = mk(4'hF, 16'hC840, 1, 4'b0010, 1, 0, 1);
    vt[2]  = mk(4'hF, 16'hC840, 1, 4'b0100, 1, 1, 0);
    vt[3]  = mk(4'hF, 16'hC840, 1, 4'b1000, 1, 2, 1);
    vt[4]  = mk(4'hF, 16'hC840, 1, 4'b0001, 1, 3, 0);
    vt[5]  = mk(4'hF, 16'hC840, 0, 4'b0000, 1, 0, 1);
    vt[6]  = mk(4'hF, 16'hC840, 0, 4'b0000, 1, 0, 1);
    vt[7]  = mk(4'hF, 16'hC840, 0, 4'b0000, 1, 0, 1);
    vt[8]  = mk(4'hF, 16'hC840, 1, 4'b0010, 1, 0, 1);
    vt[9]  = mk(4'hF, 16'hC840, 1, 4'b0100, 1, 1, 0);
    vt[10] = mk(4'h5, 16'hC840, 1, 4'b0001, 1, 2, 1);
    vt[11] = mk(4'h5, 16'hC840, 1, 4'b0100, 1, 0, 1);
    vt[12] = mk(4'h1, 16'h0000, 1, 4'b0001, 1, 2, 1);
    vt[13] = mk(4'h1, 16'h0004, 1, 4'b0001, 1, 0, 1);
    vt[14] = mk(4'h1, 16'h000F, 1, 4'b0001, 1, 0, 0);
    vt[15] = mk(4'h1, 16'h000E, 1, 4'b0001, 1, 0, 1);
    vt[16] = mk(4'h0, 16'h000E, 1, 4'b0000, 1, 0, 0);
    vt[17] = mk(4'h0, 16'h000E, 1, 4'b0000, 0, 0, 0);

    RESETN = 1'b1;
    REQ    = 4'hF;
    ADDR   = 16'hC840;
    RDY    = 1'b1;
    #1 RESETN = 1'b0;
    #2 chk("reset_async", obs(), 8'h00);
    @(negedge CLK);
    chk("reset_held", obs(), 8'h00);
    @(posedge CLK);
    #1 RESETN = 1'b1;

    for (int i = 0; i < 18; i++) begin
      REQ  = vt[i].req;
      ADDR = vt[i].addr;
      RDY  = vt[i].rdy;
      @(negedge CLK);
      chk($sformatf("vec%0d", i), obs(), vt[i].exp);
      @(posedge CLK);
      #1;
    end

    REQ  = 4'hF;
    ADDR = 16'hC840;
    RDY  = 1'b1;
    @(posedge CLK);
    #1;
    @(negedge CLK);
    RESETN = 1'b0;
    #1 chk("midreset", obs(), 8'h00);
    @(posedge CLK);
    #1 RESETN = 1'b1;
    m_reset();
    cyc(4'hF, 16'hC840, 1'b1);
    cyc(4'h6, 16'h1234, 1'b1);

    for (int i = 0; i < 400; i++) begin
      cyc(4'($urandom_range(0, 15)),
          16'($urandom),
          ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
